// File: rtl/riscv_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module   : riscv_muldiv_iter
//  Purpose  : Iterative RV32M/RV64M multiply/divide unit, one bit per cycle,
//             valid/ready on both sides, flush and optional early-out.
//  Revision : 1.0
// ============================================================================
module riscv_muldiv_iter #(
    parameter int XLEN      = 32,
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_op;
    logic            r_neg;
    logic            r_special;
    logic [XLEN-1:0] r_spec;
    logic [CW-1:0]   r_cnt;
    logic [XLEN:0]   r_acc;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_result;

    // Request decode (only meaningful at accept)
    logic            w_accept;
    logic            w_is_div;
    logic            w_a_signed;
    logic            w_b_signed;
    logic            w_sa;
    logic            w_sb;
    logic [XLEN-1:0] w_abs_a;
    logic [XLEN-1:0] w_abs_b;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_special;
    logic [XLEN-1:0] w_spec_val;
    logic            w_neg;

    assign ready_o  = (r_state == S_IDLE) & ~rst_i;
    assign valid_o  = (r_state == S_DONE);
    assign result_o = r_result;
    assign w_accept = valid_i & ready_o & ~flush_i;

    assign w_is_div   = op_i[2];
    assign w_a_signed = (op_i == 3'd0) | (op_i == 3'd1) | (op_i == 3'd2) |
                        (op_i == 3'd4) | (op_i == 3'd6);
    assign w_b_signed = (op_i == 3'd0) | (op_i == 3'd1) |
                        (op_i == 3'd4) | (op_i == 3'd6);
    assign w_sa       = w_a_signed & a_i[XLEN-1];
    assign w_sb       = w_b_signed & b_i[XLEN-1];
    assign w_abs_a    = w_sa ? ('0 - a_i) : a_i;
    assign w_abs_b    = w_sb ? ('0 - b_i) : b_i;
    assign w_div_zero = w_is_div & (b_i == '0);
    assign w_ovf      = ((op_i == 3'd4) | (op_i == 3'd6)) &
                        (a_i == {1'b1, {(XLEN-1){1'b0}}}) & (b_i == {XLEN{1'b1}});
    assign w_special  = w_div_zero | w_ovf;
    // op_i[1] selects the remainder flavour of the divide ops
    assign w_spec_val = w_div_zero ? (op_i[1] ? a_i : {XLEN{1'b1}})
                                   : (op_i[1] ? '0  : a_i);
    assign w_neg      = (w_is_div & op_i[1]) ? w_sa : (w_sa ^ w_sb);

    // One iteration step
    logic [XLEN:0]     w_mul_sum;
    logic [XLEN:0]     w_mul_pre;
    logic [XLEN:0]     w_shift;
    logic [XLEN+1:0]   w_diff;
    logic              w_ge;
    logic [XLEN:0]     w_step_acc;
    logic [XLEN-1:0]   w_step_lo;
    logic [2*XLEN-1:0] w_prod;
    logic [2*XLEN-1:0] w_prod_s;
    logic [XLEN-1:0]   w_quo_s;
    logic [XLEN-1:0]   w_rem_s;
    logic [XLEN-1:0]   w_final;

    assign w_mul_sum = r_acc + {1'b0, r_b};
    assign w_mul_pre = r_lo[0] ? w_mul_sum : r_acc;
    assign w_shift   = {r_acc[XLEN-1:0], r_lo[XLEN-1]};
    assign w_diff    = {1'b0, w_shift} - {2'b00, r_b};
    assign w_ge      = ~w_diff[XLEN+1];

    always_comb begin
        w_step_acc = r_acc;
        w_step_lo  = r_lo;
        if (r_op[2]) begin
            w_step_acc = w_ge ? w_diff[XLEN:0] : w_shift;
            w_step_lo  = {r_lo[XLEN-2:0], w_ge};
        end else begin
            w_step_acc = {1'b0, w_mul_pre[XLEN:1]};
            w_step_lo  = {w_mul_pre[0], r_lo[XLEN-1:1]};
        end
    end

    assign w_prod   = {w_step_acc[XLEN-1:0], w_step_lo};
    assign w_prod_s = r_neg ? ('0 - w_prod) : w_prod;
    assign w_quo_s  = r_neg ? ('0 - w_step_lo) : w_step_lo;
    assign w_rem_s  = r_neg ? ('0 - w_step_acc[XLEN-1:0]) : w_step_acc[XLEN-1:0];

    always_comb begin
        w_final = '0;
        if (r_special)
            w_final = r_spec;
        else if (r_op[2])
            w_final = r_op[1] ? w_rem_s : w_quo_s;
        else if (r_op == 3'd0)
            w_final = w_prod_s[XLEN-1:0];
        else
            w_final = w_prod_s[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept)
                    w_state_nxt = (EARLY_OUT && w_special) ? S_DONE : S_BUSY;
            end
            S_BUSY: begin
                if (r_cnt == CW'(1))
                    w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (ready_i)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        if (flush_i)
            w_state_nxt = S_IDLE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_op      <= '0;
            r_neg     <= 1'b0;
            r_special <= 1'b0;
            r_spec    <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_lo      <= '0;
            r_b       <= '0;
            r_result  <= '0;
        end else if (w_accept) begin
            r_op      <= op_i;
            r_neg     <= w_neg;
            r_special <= w_special;
            r_spec    <= w_spec_val;
            r_cnt     <= CW'(XLEN);
            r_acc     <= '0;
            r_lo      <= w_abs_a;
            r_b       <= w_abs_b;
            if (EARLY_OUT && w_special)
                r_result <= w_spec_val;
        end else if ((r_state == S_BUSY) && !flush_i) begin
            r_acc <= w_step_acc;
            r_lo  <= w_step_lo;
            r_cnt <= r_cnt - CW'(1);
            if (r_cnt == CW'(1))
                r_result <= w_final;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_riscv_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_riscv_muldiv_iter
//  Purpose  : Directed self-checking bench for riscv_muldiv_iter (XLEN=32).
//  Revision : 1.0
// ============================================================================
module tb_riscv_muldiv_iter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        valid_i1 = 1'b0;
    logic        valid_i0 = 1'b0;
    logic        ready_i1 = 1'b0;
    logic        ready_i0 = 1'b0;
    logic [2:0]  op_i = 3'd0;
    logic [31:0] a_i = 32'd0;
    logic [31:0] b_i = 32'd0;
    logic        ready_o1, valid_o1, ready_o0, valid_o0;
    logic [31:0] result_o1, result_o0;

    int total = 0;
    int bad   = 0;

    always #5 clk_i = ~clk_i;

    riscv_muldiv_iter #(.XLEN(32), .EARLY_OUT(1'b1)) u_dut_eo (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i1),
        .ready_o(ready_o1), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .valid_o(valid_o1), .ready_i(ready_i1), .result_o(result_o1)
    );

    riscv_muldiv_iter #(.XLEN(32), .EARLY_OUT(1'b0)) u_dut_full (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i0),
        .ready_o(ready_o0), .op_i(op_i), .a_i(a_i), .b_i(b_i),
        .valid_o(valid_o0), .ready_i(ready_i0), .result_o(result_o0)
    );

    // Issues one request, scrambles the operand inputs after accept, waits
    // (bounded) for the result, then consumes it.
    task automatic run_op(input bit sel, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] res,
                          output int lat, output bit rdy_seen);
        rdy_seen = 1'b0;
        @(negedge clk_i);
        op_i = op; a_i = a; b_i = b;
        if (sel) valid_i1 = 1'b1; else valid_i0 = 1'b1;
        @(posedge clk_i); #1;
        valid_i1 = 1'b0; valid_i0 = 1'b0;
        op_i = ~op; a_i = ~a; b_i = 32'd0;
        lat = 1;
        while (!(sel ? valid_o1 : valid_o0) && lat < 100) begin
            if (sel ? ready_o1 : ready_o0) rdy_seen = 1'b1;
            @(posedge clk_i); #1;
            lat++;
        end
        res = sel ? result_o1 : result_o0;
        @(negedge clk_i);
        if (sel) ready_i1 = 1'b1; else ready_i0 = 1'b1;
        @(posedge clk_i); #1;
        ready_i1 = 1'b0; ready_i0 = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        total++; if (ready_o1 !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready_o1); end
        total++; if (valid_o1 !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_o1); end
        total++; if (result_o1 !== 32'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", result_o1); end
        total++; if (ready_o0 !== 1'b0) begin bad++; $display("FAIL reset_ready_full got=%b exp=0", ready_o0); end
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        total++; if (ready_o1 !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b exp=1", ready_o1); end
    endtask

    task automatic test_mul_latency();
        logic [31:0] res; int lat; bit rs;
        run_op(1'b1, 3'd0, 32'd24, 32'd10, res, lat, rs);
        total++; if (res !== 32'd240) begin bad++; $display("FAIL mul_24x10 got=%h exp=%h", res, 32'd240); end
        total++; if (lat !== 33) begin bad++; $display("FAIL mul_latency got=%0d exp=33", lat); end
        total++; if (rs !== 1'b0) begin bad++; $display("FAIL mul_ready_busy got=%b exp=0", rs); end
    endtask

    task automatic test_mul_high();
        logic [2:0]  ops [6] = '{3'd1, 3'd2, 3'd3, 3'd0, 3'd1, 3'd2};
        logic [31:0] as  [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h00000002};
        logic [31:0] bs  [6] = '{32'd2, 32'd2, 32'd2, 32'd2, 32'h80000000, 32'hFFFFFFFF};
        logic [31:0] exp [6] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 32'h40000000, 32'h00000001};
        logic [31:0] res; int lat; bit rs;
        for (int i = 0; i < 6; i++) begin
            run_op(1'b1, ops[i], as[i], bs[i], res, lat, rs);
            total++;
            if (res !== exp[i]) begin
                bad++; $display("FAIL mul_vec%0d op=%0d got=%h exp=%h", i, ops[i], res, exp[i]);
            end
        end
    endtask

    task automatic test_div();
        logic [2:0]  ops [5] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd6};
        logic [31:0] as  [5] = '{32'hFFFFFFE8, 32'hFFFFFFE8, 32'd24, 32'd24, 32'd24};
        logic [31:0] bs  [5] = '{32'd10, 32'd10, 32'd10, 32'd10, 32'hFFFFFFF6};
        logic [31:0] exp [5] = '{32'hFFFFFFFE, 32'hFFFFFFFC, 32'd2, 32'd4, 32'd4};
        logic [31:0] res; int lat; bit rs;
        for (int i = 0; i < 5; i++) begin
            run_op(1'b1, ops[i], as[i], bs[i], res, lat, rs);
            total++;
            if (res !== exp[i]) begin
                bad++; $display("FAIL div_vec%0d op=%0d got=%h exp=%h", i, ops[i], res, exp[i]);
            end
        end
    endtask

    task automatic test_special();
        logic [2:0]  ops [5] = '{3'd5, 3'd6, 3'd4, 3'd4, 3'd6};
        logic [31:0] as  [5] = '{32'd24, 32'd24, 32'hFFFFFFE8, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [5] = '{32'd0, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exp [5] = '{32'hFFFFFFFF, 32'd24, 32'hFFFFFFFF, 32'h80000000, 32'd0};
        logic [31:0] res; int lat; bit rs;
        for (int i = 0; i < 5; i++) begin
            run_op(1'b1, ops[i], as[i], bs[i], res, lat, rs);
            total++;
            if (res !== exp[i] || lat !== 1) begin
                bad++; $display("FAIL special_eo%0d got=%h lat=%0d exp=%h lat=1", i, res, lat, exp[i]);
            end
            run_op(1'b0, ops[i], as[i], bs[i], res, lat, rs);
            total++;
            if (res !== exp[i] || lat !== 33) begin
                bad++; $display("FAIL special_full%0d got=%h lat=%0d exp=%h lat=33", i, res, lat, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n; bit stable_ok;
        @(negedge clk_i);
        op_i = 3'd0; a_i = 32'd7; b_i = 32'd6; valid_i1 = 1'b1;
        @(posedge clk_i); #1;
        valid_i1 = 1'b0;
        n = 0;
        while (!valid_o1 && n < 100) begin @(posedge clk_i); #1; n++; end
        stable_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i); #1;
            if (valid_o1 !== 1'b1 || result_o1 !== 32'd42) stable_ok = 1'b0;
        end
        total++; if (stable_ok !== 1'b1) begin bad++; $display("FAIL hold_stable got=%b/%h exp=1/%h", valid_o1, result_o1, 32'd42); end
        @(negedge clk_i);
        ready_i1 = 1'b1; valid_i1 = 1'b1; op_i = 3'd0; a_i = 32'd3; b_i = 32'd5;
        @(posedge clk_i); #1;
        ready_i1 = 1'b0;
        total++; if (ready_o1 !== 1'b1 || valid_o1 !== 1'b0) begin bad++; $display("FAIL handshake_no_accept got=%b/%b exp=1/0", ready_o1, valid_o1); end
        @(posedge clk_i); #1;
        valid_i1 = 1'b0;
        n = 1;
        while (!valid_o1 && n < 100) begin @(posedge clk_i); #1; n++; end
        total++; if (result_o1 !== 32'd15 || n !== 33) begin bad++; $display("FAIL next_op got=%h lat=%0d exp=%h lat=33", result_o1, n, 32'd15); end
        @(negedge clk_i); ready_i1 = 1'b1;
        @(posedge clk_i); #1; ready_i1 = 1'b0;
    endtask

    task automatic test_flush();
        bit seen;
        @(negedge clk_i);
        op_i = 3'd0; a_i = 32'd5; b_i = 32'd5; valid_i1 = 1'b1;
        @(posedge clk_i); #1;
        valid_i1 = 1'b0;
        repeat (9) @(posedge clk_i);
        @(negedge clk_i); flush_i = 1'b1;
        @(posedge clk_i); #1; flush_i = 1'b0;
        total++; if (ready_o1 !== 1'b1 || valid_o1 !== 1'b0) begin bad++; $display("FAIL flush_idle got=%b/%b exp=1/0", ready_o1, valid_o1); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin @(posedge clk_i); #1; if (valid_o1) seen = 1'b1; end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_no_valid got=%b exp=0", seen); end
        @(negedge clk_i); flush_i = 1'b1; valid_i1 = 1'b1;
        @(posedge clk_i); #1; flush_i = 1'b0; valid_i1 = 1'b0;
        total++; if (ready_o1 !== 1'b1) begin bad++; $display("FAIL flush_beats_valid got=%b exp=1", ready_o1); end
    endtask

    task automatic test_rst_midop();
        @(negedge clk_i);
        op_i = 3'd0; a_i = 32'd9; b_i = 32'd9; valid_i1 = 1'b1;
        @(posedge clk_i); #1;
        valid_i1 = 1'b0;
        repeat (5) @(posedge clk_i);
        @(negedge clk_i); rst_i = 1'b1;
        @(posedge clk_i); #1;
        total++; if (result_o1 !== 32'd0 || valid_o1 !== 1'b0 || ready_o1 !== 1'b0) begin
            bad++; $display("FAIL rst_midop got=%h/%b/%b exp=0/0/0", result_o1, valid_o1, ready_o1);
        end
        @(negedge clk_i); rst_i = 1'b0; #1;
        total++; if (ready_o1 !== 1'b1) begin bad++; $display("FAIL rst_release_ready got=%b exp=1", ready_o1); end
    endtask

    initial begin
        test_reset();
        test_mul_latency();
        test_mul_high();
        test_div();
        test_special();
        test_back_to_back();
        test_flush();
        test_rst_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
